// File: rtl/cla_pkg.sv
// Shared types for the nibble-serial carry look-ahead adder.
package cla_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla_serial_adder_if.sv
// Operand and result handshake bundle for cla_serial_adder.
interface cla_serial_adder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/carry_look_ahead_gen.sv
// 4-bit carry look-ahead adder stage: sum and carry-out from generate/propagate terms.
module carry_look_ahead_gen (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       carry
);
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    assign p = a ^ b;
    assign g = a & b;

    // Every carry is a flat sum of products of g/p and cin, with no ripple.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum   = p ^ c[3:0];
    assign carry = c[4];
endmodule

// File: rtl/cla_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per clock through a single 4-bit CLA stage,
// with operands taken and results returned over valid/ready handshakes.
module cla_serial_adder
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input logic               clk,
    input logic               rst,
    cla_serial_adder_if.slave bus
);
    localparam int unsigned NIB   = WIDTH / NIB_W;
    localparam int unsigned CNT_W = $clog2(NIB);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [CNT_W-1:0]   cnt;
    logic               carry_reg;
    logic [WIDTH-1:0]   sum_reg;
    logic               cout_reg;
    logic               ovf_reg;
    logic               in_ready_reg;
    logic               out_valid_reg;
    logic [NIB_W-1:0]   a_nib;
    logic [NIB_W-1:0]   b_nib;
    logic [NIB_W-1:0]   nib_sum;
    logic               nib_carry;
    logic               accept_c;
    logic               last_c;
    logic               release_c;

    assign a_nib = a_reg[int'(cnt) * NIB_W +: NIB_W];
    assign b_nib = b_reg[int'(cnt) * NIB_W +: NIB_W];

    carry_look_ahead_gen u_cla (
        .a     (a_nib),
        .b     (b_nib),
        .cin   (carry_reg),
        .sum   (nib_sum),
        .carry (nib_carry)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        last_c     = 1'b0;
        release_c  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    accept_c   = 1'b1;
                    state_next = ADD;
                end
            end
            ADD: begin
                if (cnt == CNT_W'(NIB - 1)) begin
                    last_c     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    release_c  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, nibble accumulation and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg         <= '0;
            b_reg         <= '0;
            cnt           <= '0;
            carry_reg     <= 1'b0;
            sum_reg       <= '0;
            cout_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            if (accept_c) begin
                a_reg        <= bus.a;
                b_reg        <= bus.b;
                carry_reg    <= bus.cin;
                cnt          <= '0;
                in_ready_reg <= 1'b0;
            end
            if (state == ADD) begin
                sum_reg[int'(cnt) * NIB_W +: NIB_W] <= nib_sum;
                carry_reg <= nib_carry;
                cnt       <= last_c ? '0 : cnt + CNT_W'(1);
                if (last_c) begin
                    out_valid_reg <= 1'b1;
                    cout_reg      <= nib_carry;
                    // Same-sign operands whose sum flips sign.
                    ovf_reg       <= (a_reg[WIDTH-1] == b_reg[WIDTH-1])
                                  && (nib_sum[NIB_W-1] != a_reg[WIDTH-1]);
                end
            end
            if (release_c) begin
                out_valid_reg <= 1'b0;
                in_ready_reg  <= 1'b1;
            end
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.sum       = sum_reg;
    assign bus.cout      = cout_reg;
    assign bus.ovf       = ovf_reg;
endmodule

// File: tb/tb_cla_serial_adder.sv
// Self-checking bench for cla_serial_adder: directed cases plus randomized traffic against an arithmetic model.
module tb_cla_serial_adder;
    localparam int unsigned W   = 16;
    localparam int unsigned NIB = W / 4;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   results = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    logic ov_prev = 1'b0;
    res_t exp_q[$];

    cla_serial_adder_if #(.WIDTH(W)) bus ();

    cla_serial_adder #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain wide addition, overflow from operand and result signs.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        logic [W:0] full;
        res_t r;
        full = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
        r.s  = full[W-1:0];
        r.c  = full[W];
        r.o  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        return r;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endfunction

    // Monitor: scoreboard of accepted pairs, checked on every cycle a result is presented.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            ov_prev = 1'b0;
        end else begin
            chk("ready_valid_exclusive", 32'(bus.in_ready & bus.out_valid), 32'd0);
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 32'(bus.out_valid), 32'd0);
                end else begin
                    chk("sum", 32'(bus.sum), 32'(exp_q[0].s));
                    chk("cout", 32'(bus.cout), 32'(exp_q[0].c));
                    chk("ovf", 32'(bus.ovf), 32'(exp_q[0].o));
                    if (!ov_prev) chk("latency", 32'(cyc - acc_cyc), 32'(NIB + 1));
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        results++;
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.a, bus.b, bus.cin));
                acc_cyc = cyc;
            end
            ov_prev = bus.out_valid && !bus.out_ready;
        end
    end

    // Call just after a rising edge; returns just after the accept edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.cin = c;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("accept_timeout", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Waits for a result, holds it off for 'hold' cycles, then takes it in one edge.
    task automatic get_result(input int hold, output res_t r);
        int n = 0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        while (!bus.out_valid && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("result_timeout", 32'(bus.out_valid), 32'd1);
        r = '{s: bus.sum, c: bus.cout, o: bus.ovf};
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_sum", 32'(bus.sum), 32'(r.s));
            chk("hold_flags", 32'({bus.cout, bus.ovf}), 32'({r.c, r.o}));
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
            chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        res_t r;
        res_t m;
        logic [W-1:0] pa [3];
        logic [W-1:0] pb [3];
        int base;
        int n;

        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;

        // Pin the reference model with hand-computed sums.
        m = model(16'h1234, 16'h0FCD, 1'b0);
        chk("model_1", 32'(m), 32'({16'h2201, 1'b0, 1'b0}));
        m = model(16'h8000, 16'h8000, 1'b1);
        chk("model_2", 32'(m), 32'({16'h0001, 1'b1, 1'b1}));
        m = model(16'h7FFF, 16'h0001, 1'b0);
        chk("model_3", 32'(m), 32'({16'h8000, 1'b0, 1'b1}));

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_sum", 32'(bus.sum), 32'd0);
        chk("rst_flags", 32'({bus.cout, bus.ovf}), 32'd0);
        @(posedge clk); #1;

        send(16'h1234, 16'h0FCD, 1'b0);
        get_result(0, r);
        chk("t1", 32'(r), 32'({16'h2201, 1'b0, 1'b0}));

        send(16'hFFFF, 16'h0001, 1'b0);
        get_result(0, r);
        chk("t2_ripple", 32'(r), 32'({16'h0000, 1'b1, 1'b0}));

        send(16'h8000, 16'h8000, 1'b1);
        get_result(0, r);
        chk("t3_neg_ovf", 32'(r), 32'({16'h0001, 1'b1, 1'b1}));

        send(16'h7FFF, 16'h0001, 1'b0);
        get_result(0, r);
        chk("t3_pos_ovf", 32'(r), 32'({16'h8000, 1'b0, 1'b1}));

        // Backpressure, with a competing pair offered while the result is held.
        send(16'hABCD, 16'h1111, 1'b1);
        bus.in_valid = 1'b1;
        bus.a = 16'h0F0F;
        bus.b = 16'h00F1;
        bus.cin = 1'b0;
        get_result(5, r);
        chk("t4_held", 32'(r), 32'({16'hBCDF, 1'b0, 1'b0}));
        send(16'h0F0F, 16'h00F1, 1'b0);
        get_result(0, r);
        chk("t4_next", 32'(r), 32'({16'h1000, 1'b0, 1'b0}));

        // Reset while cnt==2 discards the operation.
        send(16'h1111, 16'h2222, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_in_ready", 32'(bus.in_ready), 32'd1);
        chk("t5_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t5_sum", 32'(bus.sum), 32'd0);
        @(posedge clk); #1;
        send(16'h0001, 16'h0001, 1'b0);
        get_result(0, r);
        chk("t5_after", 32'(r), 32'({16'h0002, 1'b0, 1'b0}));

        // Back-to-back: in_valid held high across three pairs.
        pa[0] = 16'h0102; pb[0] = 16'h0304;
        pa[1] = 16'hF00D; pb[1] = 16'h1FF3;
        pa[2] = 16'h4000; pb[2] = 16'h4000;
        base = results;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1;
            bus.a = pa[k];
            bus.b = pb[k];
            bus.cin = 1'(k);
            n = 0;
            @(negedge clk);
            while (!bus.in_ready && n < 100) begin
                n++;
                @(negedge clk);
            end
            chk("t6_accept", 32'(bus.in_ready), 32'd1);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        n = 0;
        while (results < base + 3 && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        chk("t6_count", 32'(results - base), 32'd3);

        // Randomized traffic with random backpressure and rare resets.
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            rst = ($urandom_range(0, 199) == 0);
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.a = W'($urandom);
            bus.b = W'($urandom);
            bus.cin = 1'($urandom_range(0, 1));
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        chk("random_progress", 32'(results > base + 50), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
